// File: rtl/fp_norm_pack.sv
// fp_norm_pack: output stage of the single-precision adder datapath.
// Takes the raw significand sum (carry and hidden-bit positions included),
// normalises it one shift per clock, strips the hidden bit and emits a packed
// IEEE-754 word {sign, exp, mantissa} with {ovf, denorm, zero} flags.
// Valid/ready handshakes on both sides; one operation in flight at a time.
module fp_norm_pack #(
  parameter int MAN_W = 23,
  parameter int EXP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [MAN_W+1:0]       in_sig,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_word,
  output logic [2:0]             out_flags
);

  localparam logic [EXP_W-1:0] EXP_MAX  = '1;
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic [MAN_W-1:0] MAN_ZERO = '0;

  // Flag encodings: {ovf, denorm, zero}
  localparam logic [2:0] FLG_NONE   = 3'b000;
  localparam logic [2:0] FLG_ZERO   = 3'b001;
  localparam logic [2:0] FLG_DENORM = 3'b010;
  localparam logic [2:0] FLG_OVF    = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             sign_q;
  logic [EXP_W-1:0] exp_q;
  logic [MAN_W+1:0] sig_q;

  // Control FSM plus working registers; all outputs are registered.
  // in_ready is held low through reset and raised on the first clock after
  // release, so it is only ever high while the FSM sits in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_flags <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      sig_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign_q   <= in_sign;
            // Exponent 0 is treated as 1 so denormals share the exp==1 scale.
            exp_q    <= (in_exp == EXP_ZERO) ? EXP_ONE : in_exp;
            sig_q    <= in_sig;
            in_ready <= 1'b0;
            state    <= NORM;
          end else begin
            in_ready <= 1'b1;
          end
        end

        NORM: begin
          // Exactly one action per cycle, in priority order.
          if (sig_q == '0) begin
            out_word  <= {sign_q, EXP_ZERO, MAN_ZERO};
            out_flags <= FLG_ZERO;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (exp_q == EXP_MAX) begin
            out_word  <= {sign_q, EXP_MAX, MAN_ZERO};
            out_flags <= FLG_OVF;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (sig_q[MAN_W+1]) begin
            // Carry out: truncate LSB; exp < EXP_MAX here so no wrap.
            sig_q <= sig_q >> 1;
            exp_q <= exp_q + EXP_ONE;
          end else if (sig_q[MAN_W]) begin
            out_word  <= {sign_q, exp_q, sig_q[MAN_W-1:0]};
            out_flags <= FLG_NONE;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (exp_q == EXP_ONE) begin
            out_word  <= {sign_q, EXP_ZERO, sig_q[MAN_W-1:0]};
            out_flags <= FLG_DENORM;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            // exp > 1 here, so the decrement cannot wrap.
            sig_q <= sig_q << 1;
            exp_q <= exp_q - EXP_ONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
